// File: rtl/mul_product_accumulator.sv
// Packet-wise accumulator for the multiplier product stream: sums 2n-bit products into an acc_w-bit result.
// Build option: define MUL_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module mul_product_accumulator #(
    parameter int n     = 8,
    parameter int acc_w = 2*n+8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prod_vld,
    output logic             prod_ready,
    input  logic [2*n-1:0]   prod,
    input  logic             prod_signed,
    input  logic             prod_last,
    output logic             res_vld,
    input  logic             res_ready,
    output logic [acc_w-1:0] res,
    output logic [7:0]       res_count,
    output logic             res_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t           state_q, state_d;
    logic [acc_w-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             mode_q, mode_d;
    logic [acc_w-1:0] res_q, res_d;
    logic [7:0]       res_count_q, res_count_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_vld_q, res_vld_d;
    logic             prod_ready_q, prod_ready_d;

    logic             accept;
    logic             ext_signed;
    logic [acc_w-1:0] prod_ext;
    logic [acc_w:0]   sum_full;
    logic [acc_w-1:0] sum;
    logic             add_ovf;
    logic [acc_w-1:0] acc_add;
    logic [7:0]       count_inc;

    assign accept = prod_vld && prod_ready_q;

    // The first beat of a packet extends with its own mode flag; later beats use the latched one.
    assign ext_signed = (state_q == IDLE) ? prod_signed : mode_q;

    assign prod_ext[2*n-1:0] = prod;
    generate
        if (acc_w > 2*n) begin : g_ext
            for (genvar gi = 2*n; gi < acc_w; gi++) begin : g_bit
                assign prod_ext[gi] = ext_signed & prod[2*n-1];
            end
        end
    endgenerate

    assign sum_full = {1'b0, acc_q} + {1'b0, prod_ext};
    assign sum      = sum_full[acc_w-1:0];
    assign add_ovf  = mode_q ? ((acc_q[acc_w-1] == prod_ext[acc_w-1]) && (sum[acc_w-1] != acc_q[acc_w-1]))
                             : sum_full[acc_w];

`ifdef MUL_ACC_SATURATE_EN
    logic [acc_w-1:0] sat_val;
    // Signed overflow direction follows the shared sign of the two addends.
    assign sat_val = !mode_q ? {acc_w{1'b1}}
                   : (acc_q[acc_w-1] ? {1'b1, {(acc_w-1){1'b0}}} : {1'b0, {(acc_w-1){1'b1}}});
    assign acc_add = add_ovf ? sat_val : sum;
`else
    assign acc_add = sum;
`endif

    assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        mode_d      = mode_q;
        res_d       = res_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d = prod_signed;
                    if (prod_last) begin
                        res_d       = prod_ext;
                        res_count_d = 8'd1;
                        res_ovf_d   = 1'b0;
                        state_d     = OUT;
                    end else begin
                        acc_d   = prod_ext;
                        count_d = 8'd1;
                        ovf_d   = 1'b0;
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d   = acc_add;
                    count_d = count_inc;
                    ovf_d   = ovf_q | add_ovf;
                    if (prod_last) begin
                        res_d       = acc_add;
                        res_count_d = count_inc;
                        res_ovf_d   = ovf_q | add_ovf;
                        state_d     = OUT;
                    end
                end
            end
            OUT: begin
                if (res_vld_q && res_ready) begin
                    acc_d   = '0;
                    count_d = 8'd0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        res_vld_d    = (state_d == OUT);
        prod_ready_d = (state_d != OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= 8'd0;
            ovf_q        <= 1'b0;
            mode_q       <= 1'b0;
            res_q        <= '0;
            res_count_q  <= 8'd0;
            res_ovf_q    <= 1'b0;
            res_vld_q    <= 1'b0;
            prod_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            mode_q       <= mode_d;
            res_q        <= res_d;
            res_count_q  <= res_count_d;
            res_ovf_q    <= res_ovf_d;
            res_vld_q    <= res_vld_d;
            prod_ready_q <= prod_ready_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign res_vld    = res_vld_q;
    assign res        = res_q;
    assign res_count  = res_count_q;
    assign res_ovf    = res_ovf_q;

endmodule
